// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings and
// the filter counter width helper.
package edge_det_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter must hold values 0..FILTER_LEN-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned filter_len);
    int unsigned w;
    w = $clog2(filter_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, glitch filter, mode qualification,
// and sticky status/overflow tracking.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 1,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level_out,
  output logic       edge_pulse,
  output logic       edge_dir,
  output logic       status,
  output logic       ovf
);

  localparam int unsigned      CNT_W    = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   dir_q, dir_d;
  logic                   status_q, status_d;
  logic                   ovf_q, ovf_d;
  logic                   sync_s;
  logic                   accept_c;
  logic                   qualify_c;

  // Shift register: new sample enters at bit 0, last stage feeds the filter.
  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, data_in});
    sync_s = sync_q[SYNC_STAGES-1];
  end

  // A new level must persist FILTER_LEN consecutive cycles to be accepted.
  always_comb begin
    level_d  = level_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    if (sync_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d  = sync_s;
      cnt_d    = '0;
      accept_c = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Mode only gates reporting; the filter keeps tracking in every mode.
  always_comb begin
    qualify_c = 1'b0;
    case (mode)
      MODE_RISE: qualify_c = accept_c & sync_s;
      MODE_FALL: qualify_c = accept_c & ~sync_s;
      MODE_BOTH: qualify_c = accept_c;
      default:   qualify_c = 1'b0;
    endcase
    pulse_d = qualify_c;
    dir_d   = qualify_c & sync_s;
  end

  // Clear consumes prior events but keeps one arriving in the same cycle.
  always_comb begin
    status_d = status_q;
    ovf_d    = ovf_q;
    if (clr) begin
      status_d = pulse_q;
      ovf_d    = 1'b0;
    end else if (pulse_q) begin
      status_d = 1'b1;
      if (status_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{INIT_LEVEL}};
      level_q  <= INIT_LEVEL;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      dir_q    <= 1'b0;
      status_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      dir_q    <= dir_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
    end
  end

  assign level_out  = level_q;
  assign edge_pulse = pulse_q;
  assign edge_dir   = dir_q;
  assign status     = status_q;
  assign ovf        = ovf_q;

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: WIDTH independent channels plus a registered
// interrupt aggregating enabled sticky status bits.
module edge_detector_multi
  import edge_det_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 1,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  input  logic [WIDTH-1:0]   irq_en,
  output logic [WIDTH-1:0]   level_out,
  output logic [WIDTH-1:0]   edge_pulse,
  output logic [WIDTH-1:0]   edge_dir,
  output logic [WIDTH-1:0]   status,
  output logic [WIDTH-1:0]   ovf,
  output logic               irq
);

  logic irq_q, irq_d;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in[i]),
      .mode       (mode[2*i +: 2]),
      .clr        (clr[i]),
      .level_out  (level_out[i]),
      .edge_pulse (edge_pulse[i]),
      .edge_dir   (edge_dir[i]),
      .status     (status[i]),
      .ovf        (ovf[i])
    );
  end

  // Interrupt is a registered reduction, so it trails status by one cycle.
  always_comb begin
    irq_d = |(status & irq_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: per-scenario tasks plus a pulse scoreboard
// fed with expected (cycle, pulse, dir) events at stimulus time.
module tb_edge_detector_multi;

  localparam int unsigned W   = 4;
  localparam int          LAT = 4;  // SYNC_STAGES + FILTER_LEN - 1

  typedef struct {
    int         cyc;
    logic [3:0] pulse;
    logic [3:0] dir;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   data_in;
  logic [2*W-1:0] mode;
  logic [W-1:0]   clr;
  logic [W-1:0]   irq_en;
  logic [W-1:0]   level_out;
  logic [W-1:0]   edge_pulse;
  logic [W-1:0]   edge_dir;
  logic [W-1:0]   status;
  logic [W-1:0]   ovf;
  logic           irq;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  edge_detector_multi #(
    .WIDTH       (W),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3),
    .INIT_LEVEL  (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .mode       (mode),
    .clr        (clr),
    .irq_en     (irq_en),
    .level_out  (level_out),
    .edge_pulse (edge_pulse),
    .edge_dir   (edge_dir),
    .status     (status),
    .ovf        (ovf),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed pulse must match the oldest expected event exactly.
  always @(negedge clk) begin
    exp_t e;
    if (edge_pulse !== 4'b0000) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse cyc=%0d got pulse=%b dir=%b, expected none",
                 cyc, edge_pulse, edge_dir);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || edge_pulse !== e.pulse || (edge_dir & edge_pulse) !== e.dir) begin
          n_errors++;
          $display("FAIL pulse_event got cyc=%0d pulse=%b dir=%b, expected cyc=%0d pulse=%b dir=%b",
                   cyc, edge_pulse, edge_dir & edge_pulse, e.cyc, e.pulse, e.dir);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue an event expected LAT edges after the next sampling edge.
  task automatic expect_pulse(input logic [3:0] p, input logic [3:0] d);
    exp_t e;
    e.cyc   = cyc + 1 + LAT;
    e.pulse = p;
    e.dir   = d;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_missing_pulse got %0d pending events, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in = '0; mode = '0; clr = '0; irq_en = '0;
    step(3);
    n_checks++;
    if ({level_out, edge_pulse, edge_dir, status, ovf, irq} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_state got lvl=%b pls=%b dir=%b st=%b ovf=%b irq=%b, expected all 0",
               level_out, edge_pulse, edge_dir, status, ovf, irq);
    end
    rst = 1'b0;
    step(6);
    n_checks++;
    if (level_out !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_exit_level got %b expected 0000", level_out);
    end
  endtask

  task automatic test_latency();
    mode[1:0] = 2'b01; irq_en = 4'b0001; data_in[0] = 1'b1;
    expect_pulse(4'b0001, 4'b0001);
    step(LAT);
    n_checks++;
    if (level_out[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_early_level got %b expected 0", level_out[0]);
    end
    step(1);
    n_checks++;
    if (level_out[0] !== 1'b1 || status[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_accept got lvl=%b st=%b expected lvl=1 st=0", level_out[0], status[0]);
    end
    step(1);
    n_checks++;
    if (edge_pulse[0] !== 1'b0 || status[0] !== 1'b1 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_status got pls=%b st=%b irq=%b expected pls=0 st=1 irq=0",
               edge_pulse[0], status[0], irq);
    end
    step(1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++;
      $display("FAIL latency_irq got %b expected 1", irq);
    end
    data_in[0] = 1'b0; clr = 4'b0001; irq_en = '0;
    step(1);
    clr = '0;
    step(8);
    check_drained("latency");
  endtask

  task automatic test_glitch();
    bit ok;
    mode[3:2] = 2'b01;
    data_in[1] = 1'b1;
    step(2);
    data_in[1] = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (level_out[1] !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL glitch_reject got level change on ch1, expected level_out[1] held 0");
    end
    data_in[1] = 1'b1;
    expect_pulse(4'b0010, 4'b0010);
    step(3);
    data_in[1] = 1'b0;
    step(2);
    n_checks++;
    if (level_out[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_accept got %b expected 1", level_out[1]);
    end
    step(6);
    n_checks++;
    if (level_out[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL glitch_fall_level got %b expected 0", level_out[1]);
    end
    check_drained("glitch");
  endtask

  task automatic test_modes();
    logic [1:0] m;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: m = 2'b01;
        1: m = 2'b10;
        2: m = 2'b11;
        default: m = 2'b00;
      endcase
      mode[5:4] = m;
      data_in[2] = 1'b1;
      if (m[0]) expect_pulse(4'b0100, 4'b0100);
      step(6);
      n_checks++;
      if (level_out[2] !== 1'b1) begin
        n_errors++;
        $display("FAIL mode%0d_rise_level got %b expected 1", m, level_out[2]);
      end
      data_in[2] = 1'b0;
      if (m[1]) expect_pulse(4'b0100, 4'b0000);
      step(6);
      n_checks++;
      if (level_out[2] !== 1'b0) begin
        n_errors++;
        $display("FAIL mode%0d_fall_level got %b expected 0", m, level_out[2]);
      end
      check_drained("modes");
    end
  endtask

  task automatic test_ovf_clr();
    mode[7:6] = 2'b01;
    clr = 4'hF;
    step(1);
    clr = '0;
    for (int i = 0; i < 2; i++) begin
      data_in[3] = 1'b1;
      expect_pulse(4'b1000, 4'b1000);
      step(6);
      data_in[3] = 1'b0;
      step(6);
    end
    n_checks++;
    if (status[3] !== 1'b1 || ovf[3] !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_set got st=%b ovf=%b expected st=1 ovf=1", status[3], ovf[3]);
    end
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0;
    n_checks++;
    if (status[3] !== 1'b0 || ovf[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_only got st=%b ovf=%b expected st=0 ovf=0", status[3], ovf[3]);
    end
    data_in[3] = 1'b1;
    expect_pulse(4'b1000, 4'b1000);
    step(6);
    data_in[3] = 1'b0;
    step(6);
    // Second event arrives with status already set; clear lands on its pulse.
    data_in[3] = 1'b1;
    expect_pulse(4'b1000, 4'b1000);
    step(LAT + 1);
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0;
    n_checks++;
    if (status[3] !== 1'b1 || ovf[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_with_pulse got st=%b ovf=%b expected st=1 ovf=0", status[3], ovf[3]);
    end
    data_in[3] = 1'b0;
    step(6);
    check_drained("ovf");
  endtask

  task automatic test_reset_mid();
    irq_en = 4'hF;
    mode[1:0] = 2'b01;
    step(2);
    data_in[0] = 1'b1;
    step(LAT);
    rst = 1'b1; data_in[0] = 1'b0;
    step(1);
    n_checks++;
    if ({level_out, edge_pulse, status, ovf, irq} !== 17'd0) begin
      n_errors++;
      $display("FAIL reset_mid_filter got lvl=%b pls=%b st=%b ovf=%b irq=%b expected all 0",
               level_out, edge_pulse, status, ovf, irq);
    end
    step(1);
    rst = 1'b0;
    step(8);
    data_in[0] = 1'b1;
    expect_pulse(4'b0001, 4'b0001);
    step(LAT + 1);
    rst = 1'b1; data_in[0] = 1'b0;
    step(1);
    n_checks++;
    if ({level_out, edge_pulse, edge_dir, status, irq} !== 17'd0) begin
      n_errors++;
      $display("FAIL reset_mid_pulse got lvl=%b pls=%b dir=%b st=%b irq=%b expected all 0",
               level_out, edge_pulse, edge_dir, status, irq);
    end
    step(1);
    rst = 1'b0;
    step(8);
    n_checks++;
    if (level_out !== 4'b0000 || status !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_release got lvl=%b st=%b expected 0000 0000", level_out, status);
    end
    check_drained("reset_mid");
  endtask

  task automatic test_parallel();
    mode = 8'hFF; irq_en = 4'b0100;
    data_in = 4'hF;
    expect_pulse(4'hF, 4'hF);
    step(LAT + 2);
    n_checks++;
    if (status !== 4'hF || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL parallel_status got st=%b irq=%b expected 1111 0", status, irq);
    end
    step(1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++;
      $display("FAIL parallel_irq_set got %b expected 1", irq);
    end
    clr = 4'b0100;
    step(1);
    clr = '0;
    step(1);
    n_checks++;
    if (status !== 4'b1011 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL parallel_irq_mask got st=%b irq=%b expected 1011 0", status, irq);
    end
    data_in = '0;
    expect_pulse(4'hF, 4'h0);
    step(8);
    n_checks++;
    if (ovf !== 4'b1011) begin
      n_errors++;
      $display("FAIL parallel_ovf got %b expected 1011", ovf);
    end
    check_drained("parallel");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_modes();
    test_ovf_clr();
    test_reset_mid();
    test_parallel();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion within time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Parametrised multi-channel edge detector; next generation of the single-channel positive-edge detector.
- Per channel: input synchroniser, glitch filter, per-channel mode (rise / fall / both / off), one-cycle edge pulse with direction, and sticky status with overflow.
- An interrupt output aggregates the channels.
- Sits between asynchronous external/status inputs and interrupt/event logic.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=1).
- FILTER_LEN, 1, consecutive cycles a new level must persist before acceptance (>=1; 1 = no filtering).
- INIT_LEVEL, 0, reset value of the synchroniser and filtered level (1 bit, shared by all channels).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  raw, possibly asynchronous channel inputs.
- mode  in  2*WIDTH  per-channel mode; bits [2i+1:2i] belong to channel i.
- clr  in  WIDTH  per-channel clear for status/ovf, one-cycle pulse.
- irq_en  in  WIDTH  per-channel interrupt enable.
- level_out  out  WIDTH  filtered, synchronised level.
- edge_pulse  out  WIDTH  one-cycle pulse per qualifying edge.
- edge_dir  out  WIDTH  valid with edge_pulse; 1 = rising, 0 = falling.
- status  out  WIDTH  sticky event flag.
- ovf  out  WIDTH  sticky overflow: an event occurred while status was already set.
- irq  out  1  OR over (status & irq_en), registered.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchroniser flops and level_out = {WIDTH{INIT_LEVEL}}.
  - Filter counters = 0.
  - edge_pulse, edge_dir, status, ovf, irq = 0.
  - Reset overrides all other activity, including mid-filter and mid-pulse.
- No spurious edge at reset exit. Deasserting rst with data_in == INIT_LEVEL produces no edge_pulse.
- Synchroniser: a chain of SYNC_STAGES flops; s = last stage.
- Filter, per channel, with counter cnt of width $clog2(FILTER_LEN+1):
  - If s == level_out: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: level_out <= s, cnt <= 0, and the edge is accepted.
  - Else: cnt <= cnt+1.
  - Any return of s to level_out before acceptance restarts the count. A glitch shorter than FILTER_LEN cycles is never seen.
- Mode encoding: 00 OFF, 01 RISE, 10 FALL, 11 BOTH.
- Edge qualification:
  - An accepted edge qualifies if mode is RISE and s=1, FALL and s=0, or BOTH.
  - A qualifying edge registers edge_pulse=1 and edge_dir=s at the same clock edge that updates level_out.
  - edge_pulse is otherwise 0.
- Filtering is independent of mode:
  - level_out tracks the input even in OFF.
  - A mode change takes effect at the next acceptance; no edges are buffered or replayed.
- Latency: input stable from sampling edge k gives level_out/edge_pulse updated at edge k+SYNC_STAGES+FILTER_LEN-1. Minimum edge spacing for distinct pulses is FILTER_LEN cycles.
- Sticky status, per channel, priority top-down:
  - clr=1 and pulse=1: status<=1, ovf<=0. The clear consumes the prior event; the new event is kept.
  - clr=1, no pulse: status<=0, ovf<=0.
  - pulse=1 and status=1: ovf<=1.
  - pulse=1: status<=1.
- irq: registered, so it is 1 the cycle after the status/irq_en condition holds. Changing irq_en affects irq one cycle later.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.

Decomposition:
- Shared package edge_det_pkg:
  - Mode encodings as localparams: MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11.
  - cnt width function.
- Sub-module edge_det_chan: one channel, containing the synchroniser, filter, qualification, status and ovf.
- The top generates WIDTH instances and the irq reduction.

Test Plan:
Default configuration for all cases: WIDTH=4, SYNC_STAGES=2, FILTER_LEN=3, INIT_LEVEL=0.
- Reset/latency: hold rst 3 cycles; data_in[0] 0->1 sampled at edge k, mode[1:0]=RISE -> level_out[0]=1 and edge_pulse[0]=1, edge_dir[0]=1 exactly at edge k+4, for one cycle; status[0]=1 at k+5, irq=1 at k+6 with irq_en[0]=1.
- Glitch rejection: data_in[1] high for 2 cycles then low -> no level_out/edge_pulse change; high for 3 cycles -> accepted.
- Modes: toggle data_in[2] 0->1->0 (6 cycles each) with mode RISE, then FALL, then BOTH, then OFF -> pulses with edge_dir=1; edge_dir=0; two pulses (1 then 0); none, but level_out still follows.
- Overflow/clear: two rising events on channel 3 without clr -> status=1, ovf=1; clr[3] pulse -> both 0; clr coincident with pulse -> status=1, ovf=0.
- Reset mid-operation: assert rst while cnt=2 and during an edge_pulse -> all outputs 0 next edge; release with data_in=0 -> no pulse.
- Parallel channels: all four inputs rise together, mode BOTH -> edge_pulse=4'b1111 in the same cycle; irq follows irq_en=4'b0100 only for channel 2.
